// File: rtl/gtwizard_gt_reset_sequencer.sv
// Reset sequencer for a GT transceiver: CPLL reset, lock wait, GT reset release,
// user-ready handshake, with bounded retries and a sticky error state.
module gtwizard_gt_reset_sequencer #(
   parameter int WAIT_STARTUP_CYCLES = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int DONE_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 7
) (
   input  logic       STABLE_CLOCK_IN,
   input  logic       SOFT_RESET_IN,
   input  logic       CPLLLOCK_IN,
   input  logic       TXRESETDONE_IN,
   input  logic       RXRESETDONE_IN,
   output logic       CPLLRESET_OUT,
   output logic       GTTXRESET_OUT,
   output logic       GTRXRESET_OUT,
   output logic       TXUSERRDY_OUT,
   output logic       RXUSERRDY_OUT,
   output logic       RESET_DONE_OUT,
   output logic       ERROR_OUT,
   output logic [3:0] RETRY_COUNT_OUT,
   output logic [3:0] STATE_OUT
);

   localparam int MAX_A      = (WAIT_STARTUP_CYCLES > LOCK_TIMEOUT_CYCLES) ? WAIT_STARTUP_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_B      = (MAX_A > DONE_TIMEOUT_CYCLES) ? MAX_A : DONE_TIMEOUT_CYCLES;
   localparam int MAX_CYCLES = (MAX_B > 16) ? MAX_B : 16;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(WAIT_STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DONE_LAST    = CNT_W'(DONE_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CPLL_LAST    = CNT_W'(7);
   localparam logic [CNT_W-1:0] USRRDY_LAST  = CNT_W'(15);

   typedef enum logic [3:0] {
      ST_STARTUP   = 4'd0,
      ST_CPLL_RST  = 4'd1,
      ST_WAIT_LOCK = 4'd2,
      ST_RELEASE   = 4'd3,
      ST_WAIT_DONE = 4'd4,
      ST_USRRDY    = 4'd5,
      ST_DONE      = 4'd6,
      ST_FAIL      = 4'd7
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       retry, retry_next;
   logic [1:0]       lock_sync, tx_sync, rx_sync;
   logic             lock_s, tx_s, rx_s;
   logic             fail_hit;
   logic             cpll_rst_next, gt_rst_next, usrrdy_next, done_next, err_next;

   assign lock_s = lock_sync[1];
   assign tx_s   = tx_sync[1];
   assign rx_s   = rx_sync[1];

   // Two-stage synchronizers for the asynchronous transceiver status inputs.
   always_ff @(posedge STABLE_CLOCK_IN) begin
      if (SOFT_RESET_IN) begin
         lock_sync <= 2'b00;
         tx_sync   <= 2'b00;
         rx_sync   <= 2'b00;
      end else begin
         lock_sync <= {lock_sync[0], CPLLLOCK_IN};
         tx_sync   <= {tx_sync[0], TXRESETDONE_IN};
         rx_sync   <= {rx_sync[0], RXRESETDONE_IN};
      end
   end

   always_comb begin
      state_next = state;
      fail_hit   = 1'b0;
      retry_next = retry;
      case (state)
         ST_STARTUP:   if (cnt == STARTUP_LAST) state_next = ST_CPLL_RST;
         ST_CPLL_RST:  if (cnt == CPLL_LAST) state_next = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lock_s)                 state_next = ST_RELEASE;
            else if (cnt == LOCK_LAST)  fail_hit   = 1'b1;
         end
         ST_RELEASE:   state_next = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (!lock_s)                state_next = state;
            if (!lock_s)                fail_hit   = 1'b1;
            else if (tx_s && rx_s)      state_next = ST_USRRDY;
            else if (cnt == DONE_LAST)  fail_hit   = 1'b1;
         end
         ST_USRRDY: begin
            if (!lock_s)                 fail_hit   = 1'b1;
            else if (cnt == USRRDY_LAST) state_next = ST_DONE;
         end
         ST_DONE:      if (!lock_s || !tx_s || !rx_s) fail_hit = 1'b1;
         ST_FAIL:      state_next = ST_FAIL;
         default:      state_next = ST_STARTUP;
      endcase
      // Every failure path funnels here so retry accounting lives in one place.
      if (fail_hit) begin
         retry_next = (retry == 4'd15) ? 4'd15 : retry + 4'd1;
         state_next = (({1'b0, retry} + 5'd1) == 5'(MAX_RETRIES)) ? ST_FAIL : ST_CPLL_RST;
      end
   end

   assign cnt_next = (state_next != state) ? '0 : cnt + CNT_W'(1);

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      cpll_rst_next = 1'b0;
      gt_rst_next   = 1'b1;
      usrrdy_next   = 1'b0;
      done_next     = 1'b0;
      err_next      = 1'b0;
      case (state_next)
         ST_CPLL_RST:  cpll_rst_next = 1'b1;
         ST_RELEASE,
         ST_WAIT_DONE: gt_rst_next   = 1'b0;
         ST_USRRDY: begin
            gt_rst_next = 1'b0;
            usrrdy_next = 1'b1;
         end
         ST_DONE: begin
            gt_rst_next = 1'b0;
            usrrdy_next = 1'b1;
            done_next   = 1'b1;
         end
         ST_FAIL: begin
            cpll_rst_next = 1'b1;
            err_next      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge STABLE_CLOCK_IN) begin
      if (SOFT_RESET_IN) begin
         state           <= ST_STARTUP;
         cnt             <= '0;
         retry           <= 4'd0;
         CPLLRESET_OUT   <= 1'b0;
         GTTXRESET_OUT   <= 1'b1;
         GTRXRESET_OUT   <= 1'b1;
         TXUSERRDY_OUT   <= 1'b0;
         RXUSERRDY_OUT   <= 1'b0;
         RESET_DONE_OUT  <= 1'b0;
         ERROR_OUT       <= 1'b0;
         RETRY_COUNT_OUT <= 4'd0;
         STATE_OUT       <= 4'd0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         retry           <= retry_next;
         CPLLRESET_OUT   <= cpll_rst_next;
         GTTXRESET_OUT   <= gt_rst_next;
         GTRXRESET_OUT   <= gt_rst_next;
         TXUSERRDY_OUT   <= usrrdy_next;
         RXUSERRDY_OUT   <= usrrdy_next;
         RESET_DONE_OUT  <= done_next;
         ERROR_OUT       <= err_next;
         RETRY_COUNT_OUT <= retry_next;
         STATE_OUT       <= state_next;
      end
   end

endmodule

// File: tb/tb_gtwizard_gt_reset_sequencer.sv
// Directed bench for the GT reset sequencer with short startup/timeouts and two retries.
module tb_gtwizard_gt_reset_sequencer;

   logic       clk = 1'b0;
   logic       soft_reset = 1'b1;
   logic       cplllock = 1'b0;
   logic       txdone = 1'b0;
   logic       rxdone = 1'b0;
   logic       cpllreset, gttxreset, gtrxreset, txuserrdy, rxuserrdy;
   logic       reset_done, error_flag;
   logic [3:0] retry_count, state_code;

   int checks = 0;
   int failures = 0;
   int n;

   gtwizard_gt_reset_sequencer #(
      .WAIT_STARTUP_CYCLES(16),
      .LOCK_TIMEOUT_CYCLES(64),
      .DONE_TIMEOUT_CYCLES(64),
      .MAX_RETRIES(2)
   ) dut (
      .STABLE_CLOCK_IN(clk),
      .SOFT_RESET_IN(soft_reset),
      .CPLLLOCK_IN(cplllock),
      .TXRESETDONE_IN(txdone),
      .RXRESETDONE_IN(rxdone),
      .CPLLRESET_OUT(cpllreset),
      .GTTXRESET_OUT(gttxreset),
      .GTRXRESET_OUT(gtrxreset),
      .TXUSERRDY_OUT(txuserrdy),
      .RXUSERRDY_OUT(rxuserrdy),
      .RESET_DONE_OUT(reset_done),
      .ERROR_OUT(error_flag),
      .RETRY_COUNT_OUT(retry_count),
      .STATE_OUT(state_code)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic lock, input logic txd, input logic rxd);
      soft_reset = rst;
      cplllock   = lock;
      txdone     = txd;
      rxdone     = rxd;
   endtask

   task automatic tick(input int cycles = 1);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts ticks until the state code appears; an expired budget is a failed comparison.
   task automatic waitState(input int code, input string tag, output int count);
      count = 0;
      while (int'(state_code) != code && count < 200) begin
         tick();
         count++;
      end
      if (int'(state_code) != code) checkOutput(tag, int'(state_code), code);
   endtask

   task automatic pulseReset();
      soft_reset = 1'b1;
      tick();
      soft_reset = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_state"}, int'(state_code), 0);
      checkOutput({tag, "_err"}, int'(error_flag), 0);
      checkOutput({tag, "_retry"}, int'(retry_count), 0);
      checkOutput({tag, "_cpll"}, int'(cpllreset), 0);
      checkOutput({tag, "_gttx"}, int'(gttxreset), 1);
      checkOutput({tag, "_gtrx"}, int'(gtrxreset), 1);
      checkOutput({tag, "_usr"}, int'(txuserrdy) + int'(rxuserrdy), 0);
      checkOutput({tag, "_done"}, int'(reset_done), 0);
   endtask

   task automatic checkDone(input string tag, input int retries);
      checkOutput({tag, "_state"}, int'(state_code), 6);
      checkOutput({tag, "_rdone"}, int'(reset_done), 1);
      checkOutput({tag, "_usr"}, int'(txuserrdy) + int'(rxuserrdy), 2);
      checkOutput({tag, "_gt"}, int'(gttxreset) + int'(gtrxreset), 0);
      checkOutput({tag, "_retry"}, int'(retry_count), retries);
      checkOutput({tag, "_err"}, int'(error_flag), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset and held reset
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkResetValues("rst");
      tick(3);
      checkResetValues("rst_hold");

      // Nominal bring-up
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitState(1, "nom_to_cpll", n);
      checkOutput("nom_startup_len", n, 16);
      checkOutput("nom_cpll_on", int'(cpllreset), 1);
      n = 0;
      while (cpllreset == 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("nom_cpll_len", n, 8);
      checkOutput("nom_wait_lock", int'(state_code), 2);
      tick(5);
      cplllock = 1'b1;
      tick(2);
      checkOutput("nom_lock_sync_lat", int'(state_code), 2);
      tick();
      checkOutput("nom_release", int'(state_code), 3);
      checkOutput("nom_release_gt", int'(gttxreset) + int'(gtrxreset), 0);
      tick();
      checkOutput("nom_wait_done", int'(state_code), 4);
      tick(9);
      txdone = 1'b1;
      rxdone = 1'b1;
      tick(2);
      checkOutput("nom_done_sync_lat", int'(state_code), 4);
      tick();
      checkOutput("nom_usrrdy", int'(state_code), 5);
      checkOutput("nom_usrrdy_out", int'(txuserrdy) + int'(rxuserrdy), 2);
      checkOutput("nom_usrrdy_rdone", int'(reset_done), 0);
      waitState(6, "nom_to_done", n);
      checkOutput("nom_usrrdy_len", n, 16);
      checkDone("nom_done", 0);

      // One-cycle lock glitch in DONE
      cplllock = 1'b0;
      tick();
      cplllock = 1'b1;
      tick();
      checkOutput("glitch_still_done", int'(state_code), 6);
      tick();
      checkOutput("glitch_state", int'(state_code), 1);
      checkOutput("glitch_rdone", int'(reset_done), 0);
      checkOutput("glitch_gt", int'(gttxreset) + int'(gtrxreset), 2);
      checkOutput("glitch_retry", int'(retry_count), 1);
      waitState(6, "glitch_recover", n);
      checkDone("glitch_redone", 1);

      // RX done stuck low on the first attempt only
      pulseReset();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkResetValues("rxstuck_rst");
      waitState(2, "rxstuck_to_lock", n);
      cplllock = 1'b1;
      waitState(4, "rxstuck_to_wdone", n);
      waitState(1, "rxstuck_timeout", n);
      checkOutput("rxstuck_wdone_len", n, 64);
      checkOutput("rxstuck_retry", int'(retry_count), 1);
      checkOutput("rxstuck_gt", int'(gttxreset) + int'(gtrxreset), 2);
      rxdone = 1'b1;
      waitState(6, "rxstuck_recover", n);
      checkDone("rxstuck_done", 1);

      // Lock loss coinciding with both done rising
      pulseReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitState(2, "race_to_lock", n);
      cplllock = 1'b1;
      waitState(4, "race_to_wdone", n);
      tick(3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick(3);
      checkOutput("race_state", int'(state_code), 1);
      checkOutput("race_retry", int'(retry_count), 1);
      checkOutput("race_usr", int'(txuserrdy) + int'(rxuserrdy), 0);

      // Lock never rises: two timeouts then FAIL
      pulseReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitState(2, "nolock_to_lock1", n);
      waitState(1, "nolock_timeout1", n);
      checkOutput("nolock_lock_len1", n, 64);
      checkOutput("nolock_retry1", int'(retry_count), 1);
      waitState(2, "nolock_to_lock2", n);
      checkOutput("nolock_cpll_len2", n, 8);
      waitState(7, "nolock_timeout2", n);
      checkOutput("nolock_lock_len2", n, 64);
      checkOutput("nolock_retry2", int'(retry_count), 2);
      checkOutput("nolock_err", int'(error_flag), 1);
      checkOutput("nolock_cpll", int'(cpllreset), 1);
      checkOutput("nolock_gt", int'(gttxreset) + int'(gtrxreset), 2);
      tick(5);
      checkOutput("nolock_fail_sticky", int'(state_code), 7);

      // Soft reset from FAIL, then from a second-attempt WAIT_LOCK
      pulseReset();
      checkResetValues("failrst");
      waitState(1, "failrst_restart", n);
      checkOutput("failrst_startup_len", n, 16);
      waitState(2, "midrst_to_lock1", n);
      waitState(1, "midrst_timeout", n);
      waitState(2, "midrst_to_lock2", n);
      tick(20);
      checkOutput("midrst_pre_retry", int'(retry_count), 1);
      pulseReset();
      checkResetValues("midrst");
      waitState(2, "midrst_restart", n);
      cplllock = 1'b1;
      txdone = 1'b1;
      rxdone = 1'b1;
      waitState(6, "midrst_to_done", n);
      checkDone("midrst_done", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gtwizard_gt_reset_sequencer.md
GTWIZARD_GT_RESET_SEQUENCER -- requirements
Module: gtwizard_gt_reset_sequencer

Interface
REQ-001 SHALL have parameter WAIT_STARTUP_CYCLES, default 1024, cycles waited after reset before starting.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, max cycles in WAIT_LOCK.
REQ-003 SHALL have parameter DONE_TIMEOUT_CYCLES, default 65536, max cycles in WAIT_DONE.
REQ-004 SHALL have parameter MAX_RETRIES, default 7, range 1..15, failed attempts allowed before FAIL.
REQ-005 SHALL have STABLE_CLOCK_IN  in  1  sole clock (free-running reference clock); all logic on rising edge.
REQ-006 SHALL have SOFT_RESET_IN  in  1  synchronous, active-high reset.
REQ-007 SHALL have CPLLLOCK_IN  in  1  asynchronous CPLL lock from transceiver.
REQ-008 SHALL have TXRESETDONE_IN  in  1  asynchronous.
REQ-009 SHALL have RXRESETDONE_IN  in  1  asynchronous.
REQ-010 SHALL have CPLLRESET_OUT  out  1  CPLL reset.
REQ-011 SHALL have GTTXRESET_OUT and GTRXRESET_OUT  out  1 each  transceiver TX/RX resets (always equal).
REQ-012 SHALL have TXUSERRDY_OUT and RXUSERRDY_OUT  out  1 each  user-clock-ready (always equal).
REQ-013 SHALL have RESET_DONE_OUT  out  1  link clocks and transceiver ready.
REQ-014 SHALL have ERROR_OUT  out  1  retries exhausted.
REQ-015 SHALL have RETRY_COUNT_OUT  out  4  failed attempts so far.
REQ-016 SHALL have STATE_OUT  out  4  current state code (debug).

Function
REQ-017 All outputs SHALL be registered.
REQ-018 CPLLLOCK_IN, TXRESETDONE_IN, RXRESETDONE_IN SHALL each pass a 2-FF synchronizer; the FSM SHALL use only synchronized values (input edge to state change: 3 cycles).
REQ-019 A single cycle counter SHALL clear to 0 on every state entry and increment each cycle in the state; width SHALL cover the largest parameter.
REQ-020 States/codes: STARTUP=0, CPLL_RST=1, WAIT_LOCK=2, RELEASE=3, WAIT_DONE=4, USRRDY=5, DONE=6, FAIL=7.
REQ-021 STARTUP: GT resets=1, CPLLRESET=0; after exactly WAIT_STARTUP_CYCLES cycles -> CPLL_RST.
REQ-022 CPLL_RST: CPLLRESET=1, GT resets=1, USERRDY=0; after exactly 8 cycles -> WAIT_LOCK.
REQ-023 WAIT_LOCK: CPLLRESET=0; sync lock=1 -> RELEASE; else counter reaching LOCK_TIMEOUT_CYCLES-1 -> failure (REQ-028).
REQ-024 RELEASE: GT resets=0; unconditionally -> WAIT_DONE next cycle.
REQ-025 WAIT_DONE: both sync TX/RX done=1 -> USRRDY; sync lock=0 or counter at DONE_TIMEOUT_CYCLES-1 -> failure; lock loss has priority over done.
REQ-026 USRRDY: USERRDY=1; after exactly 16 cycles -> DONE; lock loss -> failure.
REQ-027 DONE: RESET_DONE_OUT=1, USERRDY=1, GT resets=0; sync lock=0 or either sync done=0 -> failure.
REQ-028 Failure: if RETRY_COUNT_OUT+1 == MAX_RETRIES -> FAIL, else -> CPLL_RST; RETRY_COUNT_OUT SHALL increment in both cases, saturating at 15.
REQ-029 On failure transition, GT resets SHALL reassert and USERRDY/RESET_DONE_OUT SHALL drop in the same cycle the new state takes effect.
REQ-030 FAIL: ERROR_OUT=1, CPLLRESET=1, GT resets=1, USERRDY=0, RESET_DONE_OUT=0; exits only via SOFT_RESET_IN.
REQ-031 RESET_DONE_OUT SHALL be 1 only in DONE; ERROR_OUT SHALL be 1 only in FAIL.

Reset
REQ-032 SOFT_RESET_IN=1 SHALL, at the next edge, force STARTUP, counter=0, retry=0, synchronizers=0, CPLLRESET=0, GT resets=1, USERRDY=0, RESET_DONE_OUT=0, ERROR_OUT=0, STATE_OUT=0.
REQ-033 Reset asserted in any state, including mid-timeout or FAIL, SHALL give identical behaviour to REQ-032; held reset SHALL hold those values.

Verification (WAIT_STARTUP_CYCLES=16, timeouts=64, MAX_RETRIES=2)
REQ-034 Nominal: lock rises 5 cycles after CPLL_RST exit, both done 10 cycles after RELEASE -> CPLLRESET high exactly 8 cycles, RESET_DONE_OUT=1, RETRY_COUNT_OUT=0.
REQ-035 Lock never rises -> WAIT_LOCK lasts exactly 64 cycles twice, RETRY_COUNT_OUT 1 then 2, STATE_OUT=7, ERROR_OUT=1.
REQ-036 RXRESETDONE stuck 0 on first attempt, fine on second -> one 64-cycle WAIT_DONE timeout, RETRY_COUNT_OUT=1, then DONE.
REQ-037 Lock drops for 1 cycle in DONE -> within 3 cycles RESET_DONE_OUT=0, GT resets=1, STATE_OUT=1, RETRY_COUNT_OUT=1.
REQ-038 SOFT_RESET_IN pulsed in FAIL and in WAIT_LOCK -> next cycle STATE_OUT=0, ERROR_OUT=0, RETRY_COUNT_OUT=0; full sequence restarts.
REQ-039 Lock falls same cycle both done rise in WAIT_DONE -> failure taken, not USRRDY.
